// File: rtl/alu_params_pkg.sv
// Shared ALU parameters: opcode encodings used by the ALU and its downstream stages.
package alu_params_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;
  localparam logic [3:0] ALU_MUL = 4'h7;
  localparam logic [3:0] ALU_DIV = 4'h8;

endpackage

// File: rtl/alu_wb_pkg.sv
// Types shared by the ALU writeback stage: FSM states, FIFO entry layout, wide-op test.
package alu_wb_pkg;
  import alu_params_pkg::*;

  localparam int WB_WORD_SIZE  = 16;
  localparam int WB_REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [3:0]                  op;
    logic [WB_REG_ADDR_W-1:0]    rd;
    logic [2*WB_WORD_SIZE-1:0]   result;
  } wb_entry_t;

  // Only the multiplier produces a double-width result that needs two writes.
  function automatic logic is_wide_op(input logic [3:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Synchronous FIFO buffering ALU results ahead of the register-file write sequencer.
module alu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_wb.sv
// ALU writeback stage: queues tagged results and sequences them into the register-file port.
// Optional Z/N result flags are built when ALU_WB_FLAGS_EN is defined.
module alu_result_wb
  import alu_wb_pkg::*;
#(
  parameter int WORD_SIZE  = WB_WORD_SIZE,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic [REG_ADDR_W-1:0]     in_rd,
  input  logic [2*WORD_SIZE-1:0]    in_result,
  input  logic                      rf_stall,
  output logic                      rf_we,
  output logic [REG_ADDR_W-1:0]     rf_waddr,
  output logic [WORD_SIZE-1:0]      rf_wdata,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    count
`ifdef ALU_WB_FLAGS_EN
  ,
  output logic                      flag_z,
  output logic                      flag_n
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(wb_entry_t);

  wb_state_e       state_q;
  wb_entry_t       in_entry, head;
  logic [EW-1:0]   head_raw;
  logic [CW-1:0]   fifo_count;
  logic            push, pop, fifo_full, fifo_empty;
  logic            head_wide;

  assign in_entry  = '{op: in_op, rd: in_rd, result: in_result};
  assign head      = wb_entry_t'(head_raw);
  assign head_wide = is_wide_op(head.op);

  // Readiness is a pure function of occupancy so a full FIFO never accepts, even on a pop cycle.
  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !rf_stall && (((state_q == WR_LO) && !head_wide) || (state_q == WR_HI));
  assign count    = fifo_count;
  assign busy     = (fifo_count != '0) || (state_q != IDLE);

  alu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_entry),
    .head  (head_raw),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fifo_count != '0) state_q <= WR_LO;
        WR_LO: begin
          if (!rf_stall) begin
            if (head_wide)                  state_q <= WR_HI;
            else if (fifo_count > CW'(1))   state_q <= WR_LO;
            else                            state_q <= IDLE;
          end
        end
        WR_HI: begin
          if (!rf_stall) state_q <= (fifo_count > CW'(1)) ? WR_LO : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // High-word address wraps modulo the register file size.
  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      WR_LO: begin
        rf_waddr = head.rd;
        rf_wdata = head.result[WORD_SIZE-1:0];
      end
      WR_HI: begin
        rf_waddr = head.rd + 1'b1;
        rf_wdata = head.result[2*WORD_SIZE-1:WORD_SIZE];
      end
      default: ;
    endcase
  end

  assign rf_we = ((state_q == WR_LO) || (state_q == WR_HI)) && !rf_stall && (rf_waddr != '0);

`ifdef ALU_WB_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (pop) begin
      if (head_wide) begin
        flag_z <= (head.result == '0);
        flag_n <= head.result[2*WORD_SIZE-1];
      end else begin
        flag_z <= (head.result[WORD_SIZE-1:0] == '0);
        flag_n <= head.result[WORD_SIZE-1];
      end
    end
  end
`endif

endmodule

// File: doc/alu_result_wb.md
Name: alu_result_wb

Overview:
Writeback stage directly downstream of the ALU. It buffers ALU results, each tagged with its opcode and destination register, in a small FIFO and sequences them into the register-file write port. A narrow result takes one write. An ALU_MUL result (2*WORD_SIZE wide) takes two writes: low word to rd, high word to rd+1. It absorbs register-file stalls via a valid/ready handshake toward the issue logic.

Parameters:
WORD_SIZE, 16, datapath word width; ALU result is 2*WORD_SIZE.
REG_ADDR_W, 4, register address width.
DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  ALU result present.
in_ready  out  1  stage can accept a result.
in_op  in  4  ALU opcode of the result (codes from the shared parameters header).
in_rd  in  REG_ADDR_W  destination register.
in_result  in  2*WORD_SIZE  ALU output.
rf_stall  in  1  register file cannot take a write this cycle.
rf_we  out  1  register-file write enable.
rf_waddr  out  REG_ADDR_W  write address.
rf_wdata  out  WORD_SIZE  write data.
busy  out  1  FIFO non-empty or FSM not IDLE.
count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers and count cleared; pending entries discarded.
  - FSM forced to IDLE.
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, count=0 immediately, not on the next edge.
- Push:
  - Occurs on an edge where in_valid && in_ready.
  - in_ready = (count < DEPTH). It depends on count only; no bypass.
  - When full, in_ready=0 even if a pop happens in the same cycle.
  - While in_ready=0, in_valid/in_op/in_rd/in_result must stay stable.
- FSM states: IDLE, WR_LO, WR_HI. rf_waddr/rf_wdata/rf_we are combinational from the state and the FIFO head.
- IDLE:
  - rf_we=0.
  - count>0 at an edge → WR_LO.
- WR_LO:
  - rf_waddr=head.rd, rf_wdata=head.result[WORD_SIZE-1:0].
  - rf_stall → hold the state.
  - Otherwise, if head.op==ALU_MUL → WR_HI.
  - Otherwise pop head. Go to WR_LO if count>1 after the pop accounting, else IDLE.
- WR_HI:
  - rf_waddr=head.rd+1, computed modulo 2^REG_ADDR_W (wraps to 0), rf_wdata=head.result[2*WORD_SIZE-1:WORD_SIZE].
  - rf_stall → hold the state.
  - Otherwise pop head, then next state as in WR_LO.
- rf_we = (state is WR_LO or WR_HI) && !rf_stall && rf_waddr!=0. Register 0 is never written, but the sequencing still proceeds.
- Latency: result pushed at edge t → rf_we during the cycle after edge t+1.
- Throughput: one narrow result per cycle when unstalled; a MUL result takes 2 cycles.
- Simultaneous push and pop: count unchanged; the pushed entry is queued behind the existing entries.
- ALU_DIV and all other opcodes are narrow; their upper half is ignored.
- Ordering: results retire strictly in push order.

Optional Feature:
ALU_WB_FLAGS_EN
- Defined:
  - Adds outputs flag_z (1) and flag_n (1), both reset to 0.
  - Updated on the edge that pops an entry.
  - Wide entry: Z = (full 2*WORD_SIZE result == 0), N = result MSB.
  - Narrow entry: Z and N are computed over the low WORD_SIZE bits only.
  - A write suppressed because the address is 0 still updates the flags.
- Undefined: both ports and their logic are absent.

Decomposition:
- Shared package alu_wb_pkg:
  - FSM state enum (IDLE/WR_LO/WR_HI).
  - FIFO entry struct {op, rd, result}.
  - is_wide_op() function (true for ALU_MUL).
- ALU opcode constants stay in the existing shared parameters header.
- One sub-module: alu_wb_fifo, a synchronous FIFO.
  - Parameters: DEPTH, entry width.
  - Ports: push, pop, head, count, full, empty.
  - Same clk and active-low asynchronous rst.

Test Plan:
- ADD result 0x0000_0007 to rd=3, no stall → single write, rf_we=1, waddr=3, wdata=0x0007, in the cycle after the second edge.
- MUL result 0x0001_2345 to rd=5 → consecutive writes (5, 0x2345) then (6, 0x0001); busy drops after the pop.
- MUL to rd=15, REG_ADDR_W=4 → low word written to 15; high write to address 0 suppressed (rf_we=0); FSM returns to IDLE.
- Push 3 narrow results with rf_stall held high → in_ready=0 at count=2, third result held by the source. Release the stall → writes in push order, one per cycle.
- Assert rst low mid-WR_HI with 2 entries queued → rf_we=0 and count=0 immediately; no further writes after rst rises.
- With ALU_WB_FLAGS_EN: SUB result 0x0000_8000 → flag_n=1, flag_z=0. Next ADD result 0 → flag_z=1, flag_n=0.
